mem_model: RTL and testbench
============================

MEM_MODEL -- requirements
Module: mem_model

Interface
REQ-001 Parameter NUM_PORTS, default 2, SHALL set the number of requester channels (1..8).
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width.
REQ-004 Parameter DEPTH, default 256, SHALL set the number of words; DEPTH <= 2**ADDR_W.
REQ-005 Parameter LATENCY, default 4, SHALL set the cycles from request acceptance to response; LATENCY >= 1.
REQ-006 clk  in  1  sole clock; all state on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  NUM_PORTS  per-port request present.
REQ-009 req_ready  out  NUM_PORTS  per-port request accepted this cycle when ANDed with req_valid.
REQ-010 req_write  in  NUM_PORTS  per-port 1 = write, 0 = read.
REQ-011 req_addr  in  NUM_PORTS*ADDR_W  per-port word address; port p at bits [p*ADDR_W +: ADDR_W].
REQ-012 req_wdata  in  NUM_PORTS*DATA_W  per-port write data, packed as req_addr.
REQ-013 rsp_valid  out  NUM_PORTS  one-cycle response pulse to the port that issued the request.
REQ-014 rsp_rdata  out  DATA_W  read data, valid when any rsp_valid bit is 1; 0 otherwise.
REQ-015 rsp_err  out  1  address-out-of-range flag, valid with rsp_valid.

Function
REQ-016 The block SHALL have states IDLE, BUSY and RESP, with one request in flight at a time.
REQ-017 In IDLE, req_ready SHALL be one-hot on the round-robin-granted port among ports with req_valid=1, and all-zero if none are valid; in BUSY and RESP, req_ready SHALL be 0.
REQ-018 Round-robin SHALL search from pointer ptr upward with wrap; after acceptance from port g, ptr SHALL become (g+1) mod NUM_PORTS.
REQ-019 On acceptance (IDLE, req_valid[g] & req_ready[g]) at edge T, the block SHALL latch port g, write flag, address and data; load counter with LATENCY-1; go to BUSY if LATENCY>1 else RESP.
REQ-020 A write with address < DEPTH SHALL update the array at acceptance edge T.
REQ-021 A read SHALL capture array[addr] at edge T, so the response returns the pre-T contents.
REQ-022 In BUSY, the counter SHALL decrement each cycle; at counter=1 the next state SHALL be RESP.
REQ-023 In RESP, exactly rsp_valid[g] SHALL be 1 for one cycle, with rsp_rdata = captured data for reads and 0 for writes; next state IDLE.
REQ-024 rsp_valid SHALL assert LATENCY cycles after the acceptance cycle; the next acceptance is possible LATENCY+1 cycles after the previous one.
REQ-025 Address >= DEPTH SHALL NOT modify the array and SHALL return rsp_rdata=0 with rsp_err=1; otherwise rsp_err=0.
REQ-026 A requester that drops req_valid before acceptance SHALL have no effect; requests are never queued internally.
REQ-027 Array contents are not reset; a read of a never-written location returns undefined data.

Reset
REQ-028 While rst=0, state SHALL be IDLE, ptr=0, counter=0, and req_ready, rsp_valid, rsp_rdata and rsp_err SHALL be 0 asynchronously.
REQ-029 Reset asserted mid-transaction SHALL discard the in-flight request with no response; a write already committed at acceptance stays in the array.
REQ-030 After rst releases, the first acceptance SHALL be possible at the first rising edge with rst=1.

Verification
REQ-031 Defaults: port0 writes 0xDEADBEEF to addr 0x10 at cycle T -> rsp_valid=01 at T+4, rsp_err=0; port0 reads 0x10 -> rsp_rdata=0xDEADBEEF 4 cycles after acceptance.
REQ-032 Both ports hold req_valid after reset -> accepted in order port0, port1, port0, ... with acceptances 5 cycles apart; req_ready never 11.
REQ-033 LATENCY=1: read accepted at T -> rsp_valid at T+1; next acceptance at T+2.
REQ-034 DEPTH=200, write to addr 0xF0 -> rsp_err=1; a later read of 0xF0 -> rsp_rdata=0, rsp_err=1.
REQ-035 rst driven low 2 cycles after accepting a read -> rsp_valid never pulses for it; outputs are 0 immediately; ptr=0 after release.
REQ-036 Port1 writes 0x55 to addr 3; port0's read of addr 3 is accepted at the next acceptance edge -> rsp_rdata=0x55.

Source files
------------

// File: rtl/mem_model.sv
// Multi-port word memory with round-robin arbitration and one request in flight.
// Latency: response pulse LATENCY cycles after acceptance; next accept LATENCY+1 after.
// Backpressure: req_ready is offered only in IDLE to the granted port; nothing is queued.
module mem_model #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [PTR_W-1:0]       port_q;
  logic [DATA_W-1:0]      data_q;
  logic                   err_q;
  logic [NUM_PORTS-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]      rsp_rdata_q;
  logic                   rsp_err_q;

  // Storage is deliberately left unreset; only the control path clears.
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic [ADDR_W-1:0]      addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]      wdata_arr [NUM_PORTS];
  logic                   found;
  logic [PTR_W-1:0]       gnt;
  logic [PTR_W-1:0]       cand;
  logic [NUM_PORTS-1:0]   gnt_oh;
  logic                   idle_ok;
  logic                   accept;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_write;
  logic                   in_range;
  logic [DATA_W-1:0]      rd_word;

  // Split the flat per-port buses into indexable arrays.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
      wdata_arr[p] = req_wdata[p*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting at ptr_q, wrapping, first valid port wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign gnt_oh    = found ? (NUM_PORTS'(1) << gnt) : '0;
  // Gating with rst keeps req_ready low asynchronously while reset is held.
  assign idle_ok   = (state_q == IDLE) && rst;
  assign req_ready = idle_ok ? gnt_oh : '0;
  assign accept    = idle_ok && found;

  assign sel_addr  = addr_arr[gnt];
  assign sel_wdata = wdata_arr[gnt];
  assign sel_write = req_write[gnt];
  assign in_range  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
  // Reads sample the array before any same-edge write; writes and bad addresses return 0.
  assign rd_word   = (!sel_write && in_range) ? mem_q[sel_addr] : '0;

  assign ptr_d     = (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + 1'b1;

  // Array write commits at the acceptance edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && sel_write && in_range) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  // Control FSM: accept in IDLE, count down in BUSY, pulse the response in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      port_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          if (accept) begin
            port_q <= gnt;
            ptr_q  <= ptr_d;
            err_q  <= !in_range;
            data_q <= rd_word;
            cnt_q  <= CNT_W'(LATENCY - 1);
            if (LATENCY > 1) begin
              state_q <= BUSY;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= gnt_oh;
              rsp_rdata_q <= rd_word;
              rsp_err_q   <= !in_range;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= NUM_PORTS'(1) << port_q;
            rsp_rdata_q <= data_q;
            rsp_err_q   <= err_q;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_model.sv
// Bench for mem_model: instance 0 is LATENCY=4/DEPTH=200, instance 1 is LATENCY=1/DEPTH=256.
// A transaction-level model predicts ready/response every cycle; directed scenarios add literal checks.
module tb_mem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst = 2'b00;
  logic [1:0][1:0]  vld, wr, rdy, rv;
  logic [1:0][15:0] addr;
  logic [1:0][63:0] wdat;
  logic [1:0][31:0] rdat;
  logic [1:0]       err;

  mem_model #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .DEPTH(200), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .req_addr(addr[0]), .req_wdata(wdat[0]), .rsp_valid(rv[0]), .rsp_rdata(rdat[0]), .rsp_err(err[0]));

  mem_model #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .req_addr(addr[1]), .req_wdata(wdat[1]), .rsp_valid(rv[1]), .rsp_rdata(rdat[1]), .rsp_err(err[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_model = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          nf   [2];   // first cycle at which a new acceptance is allowed
  int          mptr [2];
  bit          pend [2];
  int          pdue [2];
  int          pport[2];
  logic [31:0] pdata[2];
  bit          perr [2];
  bit          pknown[2];
  logic [31:0] mm [int];

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 0) ? 200 : 256;
  endfunction

  task automatic model_step(input int d, output logic [1:0] e_rdy, output logic [1:0] e_rv,
                            output logic [31:0] e_rd, output logic e_err, output bit known);
    e_rdy = '0; e_rv = '0; e_rd = '0; e_err = 1'b0; known = 1'b1;
    if (!rst[d]) begin
      nf[d] = 0; mptr[d] = 0; pend[d] = 1'b0;
      return;
    end
    if (pend[d] && pdue[d] == cyc) begin
      e_rv  = 2'(1 << pport[d]);
      e_rd  = pdata[d];
      e_err = perr[d];
      known = pknown[d];
      pend[d] = 1'b0;
    end
    if (cyc >= nf[d]) begin
      for (int i = 0; i < 2; i++) begin
        int p;
        p = (mptr[d] + i) % 2;
        if (e_rdy == 2'b00 && vld[d][p]) begin
          int a;
          int key;
          bit oor;
          a   = int'(addr[d][p*8 +: 8]);
          key = d * 1024 + a;
          oor = (a >= depth_of(d));
          e_rdy    = 2'(1 << p);
          pend[d]  = 1'b1;
          pport[d] = p;
          pdue[d]  = cyc + lat_of(d);
          nf[d]    = cyc + lat_of(d) + 1;
          mptr[d]  = (p + 1) % 2;
          perr[d]  = oor;
          pknown[d] = 1'b1;
          pdata[d] = '0;
          if (wr[d][p] && !oor) mm[key] = wdat[d][p*32 +: 32];
          else if (!wr[d][p] && !oor) begin
            if (mm.exists(key)) pdata[d] = mm[key];
            else pknown[d] = 1'b0;
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [1:0]  er, ev;
    logic [31:0] ed;
    logic        ee;
    bit          kn;
    if (run_model) begin
      for (int d = 0; d < 2; d++) begin
        model_step(d, er, ev, ed, ee, kn);
        chk($sformatf("d%0d_req_ready", d), rdy[d], er);
        chk($sformatf("d%0d_rsp_valid", d), rv[d], ev);
        if (kn) chk($sformatf("d%0d_rsp_rdata", d), rdat[d], ed);
        chk($sformatf("d%0d_rsp_err", d), err[d], ee);
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  typedef logic [63:0] q64_t[$];
  q64_t acc_cyc, acc_port, rsp_cyc, rsp_vec, rsp_dat, rsp_e;
  int both_rdy = 0;

  function automatic logic [63:0] get(input q64_t q, input int i);
    return (i < q.size()) ? q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic clrq();
    acc_cyc.delete(); acc_port.delete(); rsp_cyc.delete();
    rsp_vec.delete(); rsp_dat.delete(); rsp_e.delete();
  endtask

  task automatic req(input int d, input int p, input bit w, input logic [7:0] a, input logic [31:0] wd);
    vld[d][p] = 1'b1;
    wr[d][p]  = w;
    addr[d][p*8 +: 8]   = a;
    wdat[d][p*32 +: 32] = wd;
  endtask

  // Entered and left at posedge+1; records acceptances and responses per cycle.
  task automatic run(input int d, input int n, input bit hold);
    for (int k = 0; k < n; k++) begin
      logic [1:0] taken;
      #1;
      taken = vld[d] & rdy[d];
      if (rdy[d] == 2'b11) both_rdy++;
      for (int p = 0; p < 2; p++) begin
        if (taken[p]) begin
          acc_cyc.push_back(cyc);
          acc_port.push_back(p);
        end
      end
      if (rv[d] != 2'b00) begin
        rsp_cyc.push_back(cyc);
        rsp_vec.push_back(rv[d]);
        rsp_dat.push_back(rdat[d]);
        rsp_e.push_back(err[d]);
      end
      @(posedge clk); #1;
      if (!hold) vld[d] = vld[d] & ~taken;
    end
  endtask

  task automatic one(input int d, input int p, input bit w, input logic [7:0] a,
                     input logic [31:0] wd, input int n);
    req(d, p, w, a, wd);
    clrq();
    run(d, n, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    vld = '0; wr = '0; addr = '0; wdat = '0;
    #2;
    vld[0] = 2'b11;
    #1;
    chk("reset_req_ready", rdy[0], 2'b00);
    chk("reset_rsp_valid", rv[0], 2'b00);
    chk("reset_rsp_rdata", rdat[0], 32'h0);
    chk("reset_rsp_err", err[0], 1'b0);
    vld[0] = 2'b00;
    run_model = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 2'b11;

    // Write then read back with latency 4.
    one(0, 0, 1'b1, 8'h10, 32'hDEADBEEF, 6);
    chk("wr_num_acc", acc_cyc.size(), 1);
    chk("wr_latency", get(rsp_cyc, 0) - get(acc_cyc, 0), 4);
    chk("wr_rsp_vec", get(rsp_vec, 0), 2'b01);
    chk("wr_rsp_err", get(rsp_e, 0), 0);
    chk("wr_rsp_dat", get(rsp_dat, 0), 0);
    one(0, 0, 1'b0, 8'h10, 32'h0, 6);
    chk("rd_latency", get(rsp_cyc, 0) - get(acc_cyc, 0), 4);
    chk("rd_rsp_dat", get(rsp_dat, 0), 32'hDEADBEEF);

    // Pointer sits at 1: port1 write wins, port0 read follows and sees it.
    req(0, 1, 1'b1, 8'h03, 32'h55);
    req(0, 0, 1'b0, 8'h03, 32'h0);
    clrq();
    run(0, 12, 1'b0);
    chk("rr_first_port", get(acc_port, 0), 1);
    chk("rr_second_port", get(acc_port, 1), 0);
    chk("rr_gap", get(acc_cyc, 1) - get(acc_cyc, 0), 5);
    chk("rr_rsp0_vec", get(rsp_vec, 0), 2'b10);
    chk("rr_rsp1_vec", get(rsp_vec, 1), 2'b01);
    chk("rr_rsp1_dat", get(rsp_dat, 1), 32'h55);

    // Range boundary with DEPTH=200.
    one(0, 0, 1'b1, 8'hF0, 32'h12345678, 6);
    chk("oor_wr_err", get(rsp_e, 0), 1);
    one(0, 0, 1'b0, 8'hF0, 32'h0, 6);
    chk("oor_rd_err", get(rsp_e, 0), 1);
    chk("oor_rd_dat", get(rsp_dat, 0), 0);
    one(0, 1, 1'b1, 8'hC7, 32'hCAFEF00D, 6);
    chk("edge_wr_err", get(rsp_e, 0), 0);
    one(0, 1, 1'b0, 8'hC7, 32'h0, 6);
    chk("edge_rd_dat", get(rsp_dat, 0), 32'hCAFEF00D);
    chk("edge_rd_err", get(rsp_e, 0), 0);
    one(0, 0, 1'b1, 8'hC8, 32'h1, 6);
    chk("first_oor_err", get(rsp_e, 0), 1);

    // Reset in the middle of the response pulse clears outputs immediately.
    one(0, 0, 1'b0, 8'h10, 32'h0, 4);
    #1 chk("resp_before_rst", rv[0], 2'b01);
    rst[0] = 1'b0;
    #1;
    chk("async_rsp_valid", rv[0], 2'b00);
    chk("async_rsp_rdata", rdat[0], 32'h0);
    @(posedge clk); #1 rst[0] = 1'b1;

    // Reset two cycles after a read: no response, pointer back to 0.
    one(0, 0, 1'b0, 8'h10, 32'h0, 2);
    req(0, 0, 1'b0, 8'h10, 32'h0);
    req(0, 1, 1'b0, 8'h03, 32'h0);
    rst[0] = 1'b0;
    #1 chk("rst_req_ready", rdy[0], 2'b00);
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b1;
    rel = cyc;
    clrq();
    both_rdy = 0;
    run(0, 22, 1'b1);
    chk("rel_first_acc_cycle", get(acc_cyc, 0), rel);
    chk("rel_first_rsp_latency", get(rsp_cyc, 0) - get(acc_cyc, 0), 4);
    chk("alt_p0", get(acc_port, 0), 0);
    chk("alt_p1", get(acc_port, 1), 1);
    chk("alt_p2", get(acc_port, 2), 0);
    chk("alt_p3", get(acc_port, 3), 1);
    chk("alt_gap1", get(acc_cyc, 1) - get(acc_cyc, 0), 5);
    chk("alt_gap2", get(acc_cyc, 2) - get(acc_cyc, 1), 5);
    chk("never_both_ready", both_rdy, 0);
    vld[0] = 2'b00;
    clrq();
    run(0, 6, 1'b0);

    // LATENCY=1 instance: back-to-back write then read two cycles apart.
    req(1, 0, 1'b1, 8'h07, 32'hA5A5A5A5);
    req(1, 1, 1'b0, 8'h07, 32'h0);
    clrq();
    run(1, 6, 1'b0);
    chk("l1_first_port", get(acc_port, 0), 0);
    chk("l1_rsp_latency", get(rsp_cyc, 0) - get(acc_cyc, 0), 1);
    chk("l1_acc_gap", get(acc_cyc, 1) - get(acc_cyc, 0), 2);
    chk("l1_rd_vec", get(rsp_vec, 1), 2'b10);
    chk("l1_rd_dat", get(rsp_dat, 1), 32'hA5A5A5A5);
    one(1, 0, 1'b1, 8'hFF, 32'h0BADCAFE, 3);
    one(1, 0, 1'b0, 8'hFF, 32'h0, 3);
    chk("l1_top_addr_dat", get(rsp_dat, 0), 32'h0BADCAFE);
    chk("l1_top_addr_err", get(rsp_e, 0), 0);

    run_model = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
